// File: rtl/if_id_pkg.sv
// Shared constants for the IF/ID pipeline register: default widths, the NOP
// bubble encoding and the occupancy state encoding.
package if_id_pkg;

    localparam int unsigned INST_W_DEFAULT = 32;
    localparam int unsigned PC_W_DEFAULT   = 32;
    localparam int unsigned CNT_W_DEFAULT  = 16;

    // PA-RISC "OR 0,0,0", driven on the instruction bus whenever no entry is valid
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0800_0240;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/if_id_slot.sv
// One storage entry (valid + instruction + PC) with load, clear-to-NOP and
// synchronous active-high Reset.
module if_id_slot
    import if_id_pkg::*;
#(
    parameter int unsigned        INST_W   = INST_W_DEFAULT,
    parameter int unsigned        PC_W     = PC_W_DEFAULT,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] d_inst,
    input  logic [PC_W-1:0]   d_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc
);

    // Clear wins over load so a flush can never leave a live entry behind
    always_ff @(posedge clk) begin
        if (Reset || clear) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= d_inst;
            pc    <= d_pc;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// Fetch-to-decode pipeline register with valid/ready handshake, 2-entry skid
// buffer and synchronous flush. Optional perf counters: IF_ID_PERF_CNT_EN.
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int unsigned        INST_W   = INST_W_DEFAULT,
    parameter int unsigned        PC_W     = PC_W_DEFAULT,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEFAULT)
`ifdef IF_ID_PERF_CNT_EN
    ,
    parameter int unsigned        CNT_W    = CNT_W_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_from_skid;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] main_d_inst;
    logic [PC_W-1:0]   main_d_pc;

    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (Reset) state <= EMPTY;
        else       state <= state_d;
    end

    // Occupancy transitions; flush overrides everything except Reset
    always_comb begin
        state_d        = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = ONE;
                    main_load = 1'b1;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b11: main_load = 1'b1;
                    2'b10: begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end
                    2'b01: begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                    default: ;
                endcase
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                end
            end
            default: begin
                state_d    = EMPTY;
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end
        endcase
        if (flush) begin
            state_d    = EMPTY;
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end
    end

    assign main_d_inst = main_from_skid ? skid_inst : in_inst;
    assign main_d_pc   = main_from_skid ? skid_pc   : in_pc;

    if_id_slot #(
        .INST_W   (INST_W),
        .PC_W     (PC_W),
        .NOP_INST (NOP_INST)
    ) u_main (
        .clk    (clk),
        .Reset  (Reset),
        .load   (main_load),
        .clear  (main_clear),
        .d_inst (main_d_inst),
        .d_pc   (main_d_pc),
        .valid  (out_valid),
        .inst   (out_inst),
        .pc     (out_pc)
    );

    if_id_slot #(
        .INST_W   (INST_W),
        .PC_W     (PC_W),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk    (clk),
        .Reset  (Reset),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_inst (in_inst),
        .d_pc   (in_pc),
        .valid  (skid_valid),
        .inst   (skid_inst),
        .pc     (skid_pc)
    );

`ifdef IF_ID_PERF_CNT_EN
    // Saturating event counters; only Reset clears them
    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: a FIFO scoreboard of accepted
// entries is compared against out_* every cycle.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h0800_0240;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

`ifdef IF_ID_PERF_CNT_EN
    localparam int unsigned CNT_W = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
    int m_stall = 0, m_bubble = 0, m_flush = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    if_id_pipe_reg #(
        .INST_W   (32),
        .PC_W     (32),
        .NOP_INST (32'h0800_0240)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .CNT_W    (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5A3C, ~pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one cycle, advance the reference FIFO at the edge, check after it
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] pc, input logic ordy);
        logic in_acc, out_acc;
        logic [63:0] head;
        Reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_pc     = iv ? pc : $urandom();
        in_inst   = iv ? inst_of(pc) : $urandom();
        out_ready = ordy;
        in_acc  = iv && (sb.size() < 2);
        out_acc = (sb.size() > 0) && ordy;
`ifdef IF_ID_PERF_CNT_EN
        if (rst) begin
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end else begin
            if (sb.size() > 0 && !ordy && m_stall < CNT_MAX) m_stall++;
            if (sb.size() == 0 && m_bubble < CNT_MAX) m_bubble++;
            if (fl && m_flush < CNT_MAX) m_flush++;
        end
`endif
        @(posedge clk);
        if (rst || fl) sb.delete();
        else begin
            if (out_acc) void'(sb.pop_front());
            if (in_acc) sb.push_back({inst_of(pc), pc});
        end
        @(negedge clk);
        head = (sb.size() > 0) ? sb[0] : {NOP, 32'h0};
        check("in_ready",  64'(in_ready),  64'(sb.size() < 2));
        check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
        check("out_inst",  64'(out_inst),  64'(head[63:32]));
        check("out_pc",    64'(out_pc),    64'(head[31:0]));
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cnt",  64'(stall_cnt),  64'(m_stall));
        check("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
        check("flush_cnt",  64'(flush_cnt),  64'(m_flush));
`endif
    endtask

    initial begin
        int pc_ctr;
        // Reset held with in_valid high
        cycle(1, 0, 1, 32'h0000_0010, 1);
        cycle(1, 0, 1, 32'h0000_0014, 1);
        check("reset_nop_inst", 64'(out_inst), 64'(NOP));

        // Streaming, no back-pressure
        cycle(0, 0, 1, 32'h100, 1);
        cycle(0, 0, 1, 32'h104, 1);
        cycle(0, 0, 1, 32'h108, 1);
        cycle(0, 0, 0, 32'h0,   1);
        cycle(0, 0, 0, 32'h0,   1);

        // Back-pressure fills the skid; 0x208 waits until space opens
        cycle(0, 0, 1, 32'h200, 1);
        cycle(0, 0, 1, 32'h204, 0);
        cycle(0, 0, 1, 32'h208, 0);
        check("bp_held_pc", 64'(out_pc), 64'(32'h200));
        cycle(0, 0, 1, 32'h208, 0);
        cycle(0, 0, 1, 32'h208, 1);
        cycle(0, 0, 1, 32'h208, 1);
        cycle(0, 0, 0, 32'h0,   1);
        cycle(0, 0, 0, 32'h0,   1);

        // Flush while FULL with a simultaneous offer
        cycle(0, 0, 1, 32'h300, 0);
        cycle(0, 0, 1, 32'h304, 0);
        cycle(0, 1, 1, 32'h30C, 0);
        check("flush_ready", 64'(in_ready), 64'(1));
        cycle(0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 1);

        // Drain a single entry
        cycle(0, 0, 1, 32'h400, 0);
        cycle(0, 0, 0, 32'h0,   1);
        check("drain_pc", 64'(out_pc), 64'(0));

        // Random traffic with occasional flushes
        pc_ctr = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            logic iv, fl;
            iv = 1'($urandom_range(0, 3) != 0);
            fl = 1'($urandom_range(0, 15) == 0);
            cycle(0, fl, iv, 32'(pc_ctr), 1'($urandom_range(0, 2) != 0));
            pc_ctr += 4;
        end

`ifdef IF_ID_PERF_CNT_EN
        cycle(1, 0, 0, 32'h0, 0);
        cycle(0, 0, 1, 32'h500, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++)  cycle(0, 1, 0, 32'h0, 0);
        check("stall_sat", 64'(stall_cnt), 64'(4'hF));
        check("flush_3",   64'(flush_cnt), 64'(3));
        cycle(1, 1, 0, 32'h0, 0);
        check("cnt_clear", 64'({stall_cnt, bubble_cnt, flush_cnt}), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
